// File: rtl/edge_threshold_overlay.sv
// edge_threshold_overlay
//   Final stage after the Sobel edge filter. Each pixel's 4-bit edge magnitude
//   (edge_in[11:8]) is compared with an adaptive threshold. Edge pixels become
//   OVERLAY_COLOR, all other pixels pass the original video. Edge pixels are
//   counted per frame, and at end of frame the threshold is moved up or down
//   by one step so that the edge density stays inside [LOW_COUNT, HIGH_COUNT].
//
//   Build option: define EDGE_OVERLAY_DIM_EN to halve every channel of
//   non-edge pixels (dimmed background). Undefined: background unchanged.
//
// Ports
//   clk          pixel clock
//   reset        asynchronous, active-high reset
//   video_in     original RGB444 pixel, aligned with edge_in
//   edge_in      Sobel output, magnitude in [11:8]
//   ready        pixel strobe, one pixel per clk while high
//   video_out    composited RGB444 pixel, registered
//   threshold    threshold currently applied
//   edge_count   edge pixels counted in the last completed frame
//   count_valid  one-cycle pulse when edge_count / threshold update
//
// state  | meaning
// ACCUM  | counting edge pixels of the current frame
// UPDATE | one cycle after the last pixel; threshold adapts on exit
module edge_threshold_overlay #(
  parameter int          WIDTH         = 640,
  parameter int          HEIGHT        = 480,
  parameter int          BORDER        = 2,
  parameter int          INIT_THRESH   = 8,
  parameter int          MIN_THRESH    = 2,
  parameter int          LOW_COUNT     = 2000,
  parameter int          HIGH_COUNT    = 20000,
  parameter logic [11:0] OVERLAY_COLOR = 12'hF00
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [11:0] video_in,
  input  logic [11:0] edge_in,
  input  logic        ready,
  output logic [11:0] video_out,
  output logic [3:0]  threshold,
  output logic [19:0] edge_count,
  output logic        count_valid
);

  localparam logic [9:0]  X_LAST   = 10'(WIDTH - 1);
  localparam logic [9:0]  Y_LAST   = 10'(HEIGHT - 1);
  localparam logic [9:0]  BORDER_L = 10'(BORDER);
  localparam logic [3:0]  INIT_L   = 4'(INIT_THRESH);
  localparam logic [3:0]  MIN_L    = 4'(MIN_THRESH);
  localparam logic [19:0] LOW_L    = 20'(LOW_COUNT);
  localparam logic [19:0] HIGH_L   = 20'(HIGH_COUNT);
  localparam logic [19:0] ACC_MAX  = '1;

  typedef enum logic {ACCUM, UPDATE} state_t;

  state_t      state;
  logic [9:0]  x_pos;
  logic [9:0]  y_pos;
  logic [19:0] acc;

  logic        is_edge;
  logic        last_pixel;
  logic [19:0] acc_final;
  logic [11:0] background;
  logic        unused_inputs;

  assign is_edge    = (edge_in[11:8] >= threshold) && (x_pos >= BORDER_L) && (y_pos >= BORDER_L);
  assign last_pixel = (x_pos == X_LAST) && (y_pos == Y_LAST);
  // Count including the pixel on this strobe, saturating.
  assign acc_final  = (is_edge && (acc != ACC_MAX)) ? acc + 20'd1 : acc;

`ifdef EDGE_OVERLAY_DIM_EN
  assign background = {1'b0, video_in[11:9], 1'b0, video_in[7:5], 1'b0, video_in[3:1]};
  assign unused_inputs = ^{edge_in[7:0], video_in[8], video_in[4], video_in[0]};
`else
  assign background = video_in;
  assign unused_inputs = ^edge_in[7:0];
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= ACCUM;
      x_pos       <= '0;
      y_pos       <= '0;
      acc         <= '0;
      video_out   <= '0;
      threshold   <= INIT_L;
      edge_count  <= '0;
      count_valid <= 1'b0;
    end else begin
      count_valid <= 1'b0;

      if (ready) begin
        video_out <= is_edge ? OVERLAY_COLOR : background;
        if (x_pos == X_LAST) begin
          x_pos <= '0;
          y_pos <= (y_pos == Y_LAST) ? 10'd0 : y_pos + 10'd1;
        end else begin
          x_pos <= x_pos + 10'd1;
        end
        // The final count is captured into edge_count on the last pixel, so
        // acc can restart right away; a strobe during UPDATE is then simply
        // the first pixel of the next frame.
        acc <= last_pixel ? 20'd0 : acc_final;
      end

      case (state)
        ACCUM: begin
          if (ready && last_pixel) begin
            state       <= UPDATE;
            edge_count  <= acc_final;
            count_valid <= 1'b1;
          end
        end
        UPDATE: begin
          state <= ACCUM;
          // Threshold moves on exit so a pixel strobed during UPDATE still
          // sees the old value.
          if (edge_count > HIGH_L) begin
            if (threshold != 4'hF) threshold <= threshold + 4'd1;
          end else if (edge_count < LOW_L) begin
            if (threshold > MIN_L) threshold <= threshold - 4'd1;
          end
        end
        default: state <= ACCUM;
      endcase
    end
  end

endmodule
